// File: rtl/apb_regfile_slave_pkg.sv
// Shared types and sizing helpers for the APB register-file completer.
package apb_regfile_slave_pkg;

  typedef enum logic [0:0] {IDLE, ACCESS} apb_state_e;

  // Wait counter width; covers WAIT_CYCLES 0..15.
  localparam int unsigned CNT_W = 4;

  // Error codes reserved for a future status register.
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ADDR  = 2'd1;
  localparam logic [1:0] ERR_RO    = 2'd2;

  function automatic int unsigned idx_w(input int unsigned num_regs);
    return $clog2(num_regs);
  endfunction

  function automatic int unsigned strb_w(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB4 bus bundle with requester (master) and completer (slave) views.
interface apb_regfile_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_regfile_slave_wait_ctr.sv
// Loadable down-counter; zero flags that the wait states have elapsed.
module apb_regfile_slave_wait_ctr #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 completer backed by a word register file with byte strobes,
// fixed wait states, PSLVERR on bad address / read-only writes, and
// per-register write pulses for downstream logic.
module apb_regfile_slave
  import apb_regfile_slave_pkg::*;
#(
  parameter int unsigned         ADDR_WIDTH  = 32,
  parameter int unsigned         DATA_WIDTH  = 32,
  parameter int unsigned         NUM_REGS    = 16,
  parameter int unsigned         WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  apb_regfile_slave_if.slave             apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int unsigned IDX_W  = idx_w(NUM_REGS);
  localparam int unsigned STRB_W = strb_w(DATA_WIDTH);

  apb_state_e state_q, state_d;
  logic       load, cnt_zero, ready, done, err, wr_commit;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  assign idx = apb.PADDR[IDX_W+1:2];
  // Shift rather than slice so ADDR_WIDTH == IDX_W+2 needs no special case.
  assign err = (apb.PADDR[1:0] != 2'b00) || ((apb.PADDR >> (IDX_W + 2)) != '0) ||
               (apb.PWRITE && RO_MASK[idx]);

  apb_regfile_slave_wait_ctr #(
    .CNT_W (CNT_W)
  ) u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .en       (state_q == ACCESS),
    .zero     (cnt_zero)
  );

  // Ready depends only on registered state so it never combinationally follows the bus.
  assign ready = (state_q == ACCESS) && cnt_zero;

  // Next-state: setup phase starts an access; PSEL loss aborts without commit.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          state_d = ACCESS;
          load    = 1'b1;
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_d = IDLE;
        end else if (apb.PENABLE && ready) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign wr_commit = done && apb.PWRITE && !err;

  // Register file with byte-strobe merge on committed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (wr_commit) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (apb.PSTRB[k]) mem_q[idx][k*8 +: 8] <= apb.PWDATA[k*8 +: 8];
      end
    end
  end

  // Pulse fires for any committed write, even with all strobes low.
  always_comb begin
    wr_pulse_d = '0;
    if (wr_commit) wr_pulse_d[idx] = 1'b1;
  end

  // Write pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_pulse_q <= '0;
    else        wr_pulse_q <= wr_pulse_d;
  end

  // Response outputs, zeroed outside a completing cycle.
  always_comb begin
    apb.PREADY  = ready;
    apb.PSLVERR = ready && err;
    apb.PRDATA  = '0;
    if (ready && !apb.PWRITE && !err) apb.PRDATA = mem_q[idx];
  end

  // Flatten register contents for downstream consumers.
  always_comb begin
    regs_q = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_q[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
  end

  assign wr_pulse = wr_pulse_q;
endmodule
